instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/rv_core_pkg.sv | 10 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared core-wide constants: datapath width, instruction size and default
// reset fetch address.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and a synchronous flush.
// Read data is forced to zero while empty so that stale entries never leak.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A write into a full FIFO is still accepted when a read frees a slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, tags them in
// order, buffers returned instructions for decode and handles redirects.
module instr_fetch_queue
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] in_pc,
  input  logic            pc_load,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_count;

  logic [XLEN-1:0] tag_rd_data;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;
  logic            tag_full;

  logic            q_empty;
  logic [CW-1:0]   q_count;

  logic            credit_ok;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_keep;
  logic            pop;

  // Responses with no tag behind them (e.g. left over from before reset) are ignored.
  assign rsp_live = imem_rsp_valid && !tag_empty;
  assign rsp_keep = rsp_live && !pc_load && (drop_count == '0);

  // Every live request must have a guaranteed queue slot; dropped-but-unreturned
  // requests still hold tag FIFO entries, so the tag FIFO must have room too.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(DEPTH);
  assign tag_full       = (tag_count == CW'(DEPTH));
  assign imem_req_valid = rst_n && !pc_load && credit_ok && !tag_full;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = !q_empty;
  assign pop        = inst_valid && inst_ready && !pc_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else if (pc_load) begin
      // Everything still in the tag FIFO after this cycle becomes stale.
      fetch_pc    <= in_pc;
      outstanding <= '0;
      drop_count  <= drop_count + outstanding - CW'(rsp_live);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
      if (rsp_live && (drop_count != '0)) drop_count <= drop_count - CW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (1'b0),
    .wr_en   (req_fire),
    .wr_data (fetch_pc),
    .rd_en   (rsp_live),
    .rd_data (tag_rd_data),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (pc_load),
    .wr_en   (rsp_keep),
    .wr_data ({tag_rd_data, imem_rsp_data}),
    .rd_en   (pop),
    .rd_data ({inst_pc, inst_data}),
    .empty   (q_empty),
    .count   (q_count)
  );

  // The credit rule makes a kept response into a full queue impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && (q_count == CW'(DEPTH))));

endmodule
